matvec_mac: RTL and testbench
=============================

MATVEC_MAC -- requirements
Module: matvec_mac

Interface
REQ-001 SHALL have parameter NROW, default 16, meaning rows of W and elements of y.
REQ-002 SHALL have parameter NCOL, default 16, meaning columns of W and elements of x.
REQ-003 SHALL have parameter BITWIDTH, default 18, meaning signed fixed-point word width.
REQ-004 SHALL have parameter FRAC, default 11, meaning fractional bits (1.0 = 2^FRAC).
REQ-005 SHALL derive ADDR_BITWIDTH = ceil(log2(NCOL)) and ACC_BITWIDTH = 2*BITWIDTH + ADDR_BITWIDTH.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, request to compute y = W*x.
REQ-009 SHALL have port xVector, input, NCOL*BITWIDTH, element j at [j*BITWIDTH +: BITWIDTH].
REQ-010 SHALL have port weightColumn, input, NROW*BITWIDTH, W[i][address] at [i*BITWIDTH +: BITWIDTH], from the weight RAM.
REQ-011 SHALL have port address, output, ADDR_BITWIDTH, column index to the weight RAM.
REQ-012 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-013 SHALL have port yValid, output, 1, one-cycle pulse marking yVector updated.
REQ-014 SHALL have port yVector, output, NROW*BITWIDTH, result element i at [i*BITWIDTH +: BITWIDTH], held until next result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE, start=1 SHALL latch xVector, clear all accumulators, set address=0, col counter=0, go RUN.
REQ-017 Weight RAM returns W[:,address] one cycle after address is registered (RAM updates on falling edge); SHALL sample weightColumn at the rising edge following each address.
REQ-018 In RUN, each edge k=1..NCOL after acceptance SHALL add W[i][k-1]*x[k-1] to acc[i] for all i in parallel, and set address=k (address=0 when k=NCOL, never NCOL).
REQ-019 After the NCOL-th accumulate SHALL go DONE; on the next edge SHALL load yVector, pulse yValid for one cycle, go IDLE.
REQ-020 Latency SHALL be start-accept edge to yValid high = NCOL+1 cycles; throughput one op per NCOL+2 cycles with start held high.
REQ-021 start in RUN or DONE SHALL be ignored (no restart, no queuing).
REQ-022 Arithmetic SHALL be signed two's complement; product 2*BITWIDTH bits, accumulated exact in ACC_BITWIDTH.
REQ-023 Output SHALL be acc arithmetic-shifted right by FRAC (truncation toward minus infinity), then saturated to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-024 Saturation SHALL apply only at output, never to intermediate accumulation.
REQ-025 xVector changes after acceptance SHALL not affect the running operation.

Reset
REQ-026 reset SHALL force state=IDLE, address=0, busy=0, yValid=0, yVector=0, accumulators=0, counter=0.
REQ-027 reset mid-operation SHALL abort with no yValid pulse; reset SHALL take priority over start.

Structure
REQ-028 Shared package/header dot_prod_pkg SHALL hold BITWIDTH, FRAC, saturation limits and the state encoding.
REQ-029 One sub-module mac_lane (one row: multiply, accumulate, shift, saturate) SHALL be instantiated NROW times via generate.

Verification (NROW=NCOL=4, BITWIDTH=18, FRAC=11)
REQ-030 W=identity (2048 on diagonal), x=[2048,4096,6144,8192], start one cycle -> address 0,1,2,3,0; yValid 5 cycles after accept; y=[2048,4096,6144,8192].
REQ-031 W all 32768, x all 32768 -> y all 131071; W all -32768, same x -> y all -131072.
REQ-032 W[0][0]=1024, x[0]=3, others 0 -> y[0]=1; x[0]=-1, W[0][0]=2048 -> y[0]=-1.
REQ-033 start pulsed again 2 cycles after accept -> ignored; exactly one yValid, correct result.
REQ-034 reset at cycle 2 of RUN -> no yValid, address=0, busy=0; following start gives correct result.
REQ-035 start held high 3 ops, x changed each accept -> yValid every 6 cycles, each result matches its latched x.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// Shared word format, saturation limits and controller state encoding for the matrix-vector MAC.
package dot_prod_pkg;

    localparam int unsigned BITWIDTH = 18;
    localparam int unsigned FRAC     = 11;

    localparam int SAT_MAX = (1 <<< (BITWIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 <<< (BITWIDTH - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matvec_mac_if.sv
// Start/operand/result bundle plus the weight-RAM column port of the matrix-vector MAC.
interface matvec_mac_if #(
    parameter int unsigned NROW     = 16,
    parameter int unsigned NCOL     = 16,
    parameter int unsigned BITWIDTH = 18
);
    localparam int unsigned ADDR_BITWIDTH = $clog2(NCOL);

    logic                       start;
    logic [NCOL*BITWIDTH-1:0]   xVector;
    logic [NROW*BITWIDTH-1:0]   weightColumn;
    logic [ADDR_BITWIDTH-1:0]   address;
    logic                       busy;
    logic                       yValid;
    logic [NROW*BITWIDTH-1:0]   yVector;

    modport master (
        output start, xVector, weightColumn,
        input  address, busy, yValid, yVector
    );

    modport slave (
        input  start, xVector, weightColumn,
        output address, busy, yValid, yVector
    );
endinterface

// File: rtl/mac_lane.sv
// One output row: exact signed multiply-accumulate, then floor-shift by FRAC and saturate.
module mac_lane #(
    parameter int unsigned BITWIDTH     = 18,
    parameter int unsigned FRAC         = 11,
    parameter int unsigned ACC_BITWIDTH = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [BITWIDTH-1:0] w,
    input  logic signed [BITWIDTH-1:0] x,
    output logic signed [BITWIDTH-1:0] y_c
);
    localparam int unsigned EXT = ACC_BITWIDTH - BITWIDTH + 1;
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_HI = {{EXT{1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_LO = {{EXT{1'b1}}, {(BITWIDTH-1){1'b0}}};

    logic signed [2*BITWIDTH-1:0]   prod_c;
    logic signed [ACC_BITWIDTH-1:0] acc;
    logic signed [ACC_BITWIDTH-1:0] shifted_c;

    assign prod_c = w * x;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_BITWIDTH'(prod_c);
        end
    end

    // Saturation happens only here; the accumulator itself never clips.
    always_comb begin
        shifted_c = acc >>> FRAC;
        y_c       = shifted_c[BITWIDTH-1:0];
        if (shifted_c > SAT_HI) begin
            y_c = SAT_HI[BITWIDTH-1:0];
        end else if (shifted_c < SAT_LO) begin
            y_c = SAT_LO[BITWIDTH-1:0];
        end
    end
endmodule

// File: rtl/matvec_mac.sv
// y = W*x controller: streams weight columns from RAM one per cycle into NROW parallel MAC lanes.
module matvec_mac
    import dot_prod_pkg::*;
#(
    parameter int unsigned NROW     = 16,
    parameter int unsigned NCOL     = 16,
    parameter int unsigned BITWIDTH = dot_prod_pkg::BITWIDTH,
    parameter int unsigned FRAC     = dot_prod_pkg::FRAC
) (
    input  logic         clk,
    input  logic         reset,
    matvec_mac_if.slave  bus
);
    localparam int unsigned ADDR_BITWIDTH = $clog2(NCOL);
    localparam int unsigned ACC_BITWIDTH  = 2 * BITWIDTH + ADDR_BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    state_t                     state;
    logic [NCOL*BITWIDTH-1:0]   x_lat;
    logic [ADDR_BITWIDTH-1:0]   col;
    logic                       clear_c;
    logic                       acc_en_c;
    logic [BITWIDTH-1:0]        x_sel_c;
    logic [NROW*BITWIDTH-1:0]   y_c;

    assign clear_c  = (state == IDLE) && bus.start;
    assign acc_en_c = (state == RUN);
    // Column k-1 of W arrives on the edge after address k-1 was issued; col tracks it.
    assign x_sel_c  = x_lat[col*BITWIDTH +: BITWIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x_lat       <= '0;
            col         <= '0;
            bus.address <= '0;
            bus.busy    <= 1'b0;
            bus.yValid  <= 1'b0;
            bus.yVector <= '0;
        end else begin
            bus.yValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_lat       <= bus.xVector;
                        col         <= '0;
                        bus.address <= '0;
                        bus.busy    <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (col == LAST_COL) begin
                        col         <= '0;
                        bus.address <= '0;
                        state       <= DONE;
                    end else begin
                        col         <= col + 1'b1;
                        bus.address <= col + 1'b1;
                    end
                end
                DONE: begin
                    bus.yVector <= y_c;
                    bus.yValid  <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NROW; g++) begin : g_lane
        mac_lane #(
            .BITWIDTH     (BITWIDTH),
            .FRAC         (FRAC),
            .ACC_BITWIDTH (ACC_BITWIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear_c),
            .en    (acc_en_c),
            .w     (bus.weightColumn[g*BITWIDTH +: BITWIDTH]),
            .x     (x_sel_c),
            .y_c   (y_c[g*BITWIDTH +: BITWIDTH])
        );
    end
endmodule

// File: tb/tb_matvec_mac.sv
// Randomized self-checking bench for matvec_mac with a behavioural weight RAM and y = W*x reference.
module tb_matvec_mac;
    localparam int NROW = 4;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int FR   = 11;
    localparam longint YMAX = (64'sd1 <<< (BW - 1)) - 1;
    localparam longint YMIN = -(64'sd1 <<< (BW - 1));

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   w_mem [NROW][NCOL];
    int   x_cur [NCOL];

    matvec_mac_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus ();

    matvec_mac #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .FRAC(FR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM: column presented on the falling edge after the address is registered.
    always @(negedge clk) begin
        for (int i = 0; i < NROW; i++)
            bus.weightColumn[i*BW +: BW] <= BW'(w_mem[i][bus.address]);
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] y_at(int i);
        logic signed [BW-1:0] v;
        v = bus.yVector[i*BW +: BW];
        return 64'(v);
    endfunction

    function automatic logic signed [63:0] ref_y(int i, int xl[NCOL]);
        longint acc;
        acc = 0;
        for (int j = 0; j < NCOL; j++)
            acc += longint'(w_mem[i][j]) * longint'(xl[j]);
        acc = acc >>> FR;
        if (acc > YMAX) acc = YMAX;
        if (acc < YMIN) acc = YMIN;
        return 64'(acc);
    endfunction

    task automatic load_x();
        for (int j = 0; j < NCOL; j++)
            bus.xVector[j*BW +: BW] = BW'(x_cur[j]);
    endtask

    function automatic int rnd_word(int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    task automatic rand_w(int mag);
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++)
                w_mem[i][j] = rnd_word(mag);
    endtask

    task automatic rand_x(int mag);
        for (int j = 0; j < NCOL; j++)
            x_cur[j] = rnd_word(mag);
        load_x();
    endtask

    // One operation: accept, scramble x, then expect yValid exactly NCOL+1 edges later.
    task automatic run_op(input string tag, input bit chk_addr, input int restart_at);
        int xl [NCOL];
        xl = x_cur;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_acc"}, 64'(bus.busy), 64'd1);
        if (chk_addr) check({tag, "_addr0"}, 64'(bus.address), 64'd0);
        rand_x(131071);
        for (int c = 1; c <= NCOL + 1; c++) begin
            if (c == restart_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            if (chk_addr && c <= NCOL)
                check($sformatf("%s_addr%0d", tag, c), 64'(bus.address), 64'(c % NCOL));
            if (c <= NCOL)
                check($sformatf("%s_novalid%0d", tag, c), 64'(bus.yValid), 64'd0);
        end
        check({tag, "_valid"}, 64'(bus.yValid), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        for (int i = 0; i < NROW; i++)
            check($sformatf("%s_y%0d", tag, i), y_at(i), ref_y(i, xl));
        tick();
        check({tag, "_pulse_end"}, 64'(bus.yValid), 64'd0);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int xb [3][NCOL];
        int xl [NCOL];
        bit seen;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++)
                w_mem[i][j] = 0;
        for (int j = 0; j < NCOL; j++) x_cur[j] = 0;
        load_x();
        tick();
        bus.start = 1'b1;
        tick();
        check("rst_addr", 64'(bus.address), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_valid", 64'(bus.yValid), 64'd0);
        check("rst_y", 64'(bus.yVector), 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        tick();

        // Identity weights with address sequence 0,1,2,3,0.
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++)
                w_mem[i][j] = (i == j) ? 2048 : 0;
        for (int j = 0; j < NCOL; j++) x_cur[j] = 2048 * (j + 1);
        load_x();
        run_op("ident", 1'b1, 0);
        for (int i = 0; i < NROW; i++)
            check($sformatf("ident_const%0d", i), y_at(i), 64'(2048 * (i + 1)));

        // Positive and negative saturation.
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++) w_mem[i][j] = 32768;
        for (int j = 0; j < NCOL; j++) x_cur[j] = 32768;
        load_x();
        run_op("satp", 1'b0, 0);
        check("satp_const", y_at(2), 64'sd131071);
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++) w_mem[i][j] = -32768;
        for (int j = 0; j < NCOL; j++) x_cur[j] = 32768;
        load_x();
        run_op("satn", 1'b0, 0);
        check("satn_const", y_at(1), -64'sd131072);

        // Floor-shift rounding: small positive and -1 results.
        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++) w_mem[i][j] = 0;
        w_mem[0][0] = 1024;
        for (int j = 0; j < NCOL; j++) x_cur[j] = 0;
        x_cur[0] = 3;
        load_x();
        run_op("floorp", 1'b0, 0);
        check("floorp_const", y_at(0), 64'sd1);
        w_mem[0][0] = 2048;
        x_cur[0] = -1;
        load_x();
        run_op("floorn", 1'b0, 0);
        check("floorn_const", y_at(0), -64'sd1);

        // Restart request during RUN is ignored.
        rand_w(131071);
        rand_x(131071);
        run_op("restart", 1'b0, 2);

        // Random operations at full range and at mid range (no saturation).
        for (int n = 0; n < 6; n++) begin
            rand_w((n % 2 == 0) ? 131071 : 4096);
            rand_x((n % 2 == 0) ? 131071 : 4096);
            run_op($sformatf("rand%0d", n), 1'b0, 0);
        end

        // Abort mid-operation with reset.
        rand_w(131071);
        rand_x(131071);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_addr", 64'(bus.address), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_valid", 64'(bus.yValid), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.yValid) seen = 1'b1;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        rand_x(131071);
        run_op("post_abort", 1'b0, 0);

        // Start held high for three back-to-back operations, x changed after each accept.
        rand_w(131071);
        for (int n = 0; n < 3; n++)
            for (int j = 0; j < NCOL; j++) xb[n][j] = rnd_word(131071);
        x_cur = xb[0];
        load_x();
        bus.start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("b2b%0d_busy", n), 64'(bus.busy), 64'd1);
            xl = xb[n];
            if (n < 2) x_cur = xb[n + 1];
            else for (int j = 0; j < NCOL; j++) x_cur[j] = rnd_word(131071);
            load_x();
            seen = 1'b0;
            for (int c = 1; c <= NCOL; c++) begin
                tick();
                if (bus.yValid) seen = 1'b1;
            end
            check($sformatf("b2b%0d_early", n), 64'(seen), 64'd0);
            tick();
            check($sformatf("b2b%0d_valid", n), 64'(bus.yValid), 64'd1);
            for (int i = 0; i < NROW; i++)
                check($sformatf("b2b%0d_y%0d", n, i), y_at(i), ref_y(i, xl));
        end
        bus.start = 1'b0;
        tick();
        check("b2b_end_valid", 64'(bus.yValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
